// File: rtl/fanout_sched_pkg.sv
// Shared types and limits for the eager-fork fanout scheduler.
package fanout_sched_pkg;

    localparam int NUM_OUT_MAX = 8;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        RECONF = 2'd2
    } state_e;

endpackage

// File: rtl/fanout_ready_reduce.sv
// Reduces per-port mask/sent/ready into one "every owed consumer can take it now" flag.
module fanout_ready_reduce
    import fanout_sched_pkg::*;
#(
    parameter int NUM_OUT = 6
) (
    input  logic [NUM_OUT-1:0] mask,
    input  logic [NUM_OUT-1:0] sent,
    input  logic [NUM_OUT-1:0] ready,
    output logic               done
);

    logic [NUM_OUT-1:0] owed;

    assign owed = mask & ~sent;
    assign done = &(~owed | ready);

endmodule

// File: rtl/fanout_sched.sv
// Eager-fork scheduler: one registered token slot fanned out to NUM_OUT consumers,
// with in-flight-safe mask reconfiguration and a saturating stall counter.
module fanout_sched
    import fanout_sched_pkg::*;
#(
    parameter int NUM_OUT = 6,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready,
    input  logic               cfg_en,
    input  logic [NUM_OUT-1:0] cfg_mask,
    input  logic               flush,
    input  logic               cnt_clr,
    output logic [NUM_OUT-1:0] mask_q,
    output logic               busy,
    output logic [CNT_W-1:0]   stall_cnt
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NUM_OUT-1:0] sent_q, sent_d;
    logic [NUM_OUT-1:0] mask_d;
    logic [NUM_OUT-1:0] pend_mask_q, pend_mask_d;
    logic [NUM_OUT-1:0] fire;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               ready_ok;
    logic               done;

    fanout_ready_reduce #(
        .NUM_OUT (NUM_OUT)
    ) u_ready_reduce (
        .mask  (mask_q),
        .sent  (sent_q),
        .ready (out_ready),
        .done  (ready_ok)
    );

    assign busy      = (state_q != EMPTY);
    assign done      = busy & ready_ok;
    assign fire      = out_valid & out_ready;
    assign out_data  = data_q;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            data_q      <= '0;
            sent_q      <= '0;
            mask_q      <= '0;
            pend_mask_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sent_q      <= sent_d;
            mask_q      <= mask_d;
            pend_mask_q <= pend_mask_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sent_d      = sent_q;
        mask_d      = mask_q;
        pend_mask_d = pend_mask_q;

        if (flush) begin
            state_d = EMPTY;
            sent_d  = '0;
            if (cfg_en) begin
                mask_d = cfg_mask;
            end else if (state_q == RECONF) begin
                mask_d = pend_mask_q;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (cfg_en) begin
                        mask_d = cfg_mask;
                    end else if (in_valid && (mask_q != '0)) begin
                        data_d  = in_data;
                        sent_d  = '0;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (done) begin
                        sent_d = '0;
                        if (cfg_en) begin
                            mask_d  = cfg_mask;
                            state_d = EMPTY;
                        end else if (in_valid) begin
                            data_d = in_data;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else begin
                        sent_d = sent_q | fire;
                        if (cfg_en) begin
                            pend_mask_d = cfg_mask;
                            state_d     = RECONF;
                        end
                    end
                end
                RECONF: begin
                    // The old mask keeps governing delivery; a same-cycle cfg_en is the newest mask.
                    if (cfg_en) begin
                        pend_mask_d = cfg_mask;
                    end
                    if (done) begin
                        mask_d  = cfg_en ? cfg_mask : pend_mask_q;
                        sent_d  = '0;
                        state_d = EMPTY;
                    end else begin
                        sent_d = sent_q | fire;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    sent_d  = '0;
                end
            endcase
        end

        stall_d = stall_q;
        if (cnt_clr) begin
            stall_d = '0;
        end else if (busy && !done && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = '0;
        if (busy) begin
            out_valid = mask_q & ~sent_q;
        end
        if (!flush) begin
            unique case (state_q)
                EMPTY:   in_ready = ~cfg_en;
                FULL:    in_ready = done & ~cfg_en;
                default: in_ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fanout_sched.sv
// Self-checking bench for fanout_sched: directed scenarios plus randomized traffic
// compared against a token/owed-set reference model.
module tb_fanout_sched;

    localparam int N  = 6;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int VW = 2 + 2 * N + DW + CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [N-1:0]  out_valid;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_ready;
    logic          cfg_en;
    logic [N-1:0]  cfg_mask;
    logic          flush;
    logic          cnt_clr;
    logic [N-1:0]  mask_q;
    logic          busy;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    fanout_sched #(
        .NUM_OUT (N),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cfg_en    (cfg_en),
        .cfg_mask  (cfg_mask),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .mask_q    (mask_q),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a held token plus the set of consumers still owed it.
    bit            m_have;
    logic [DW-1:0] m_tok;
    logic [N-1:0]  m_rem;
    logic [N-1:0]  m_act;
    bit            m_pendv;
    logic [N-1:0]  m_pend;
    logic [CW-1:0] m_stall;
    bit            e_done;
    bit            e_in_ready;
    logic [N-1:0]  e_out_valid;

    logic [VW-1:0] obs;
    assign obs = {in_ready, out_valid, busy, out_data, mask_q, stall_cnt};

    function automatic logic [VW-1:0] exp_vec();
        return {e_in_ready, e_out_valid, m_have, m_tok, m_act, m_stall};
    endfunction

    task automatic model_reset();
        m_have  = 0;
        m_tok   = '0;
        m_rem   = '0;
        m_act   = '0;
        m_pendv = 0;
        m_pend  = '0;
        m_stall = '0;
    endtask

    task automatic model_eval();
        bit all_take;
        all_take = 1;
        for (int i = 0; i < N; i++) begin
            if (m_rem[i] && !out_ready[i]) all_take = 0;
        end
        e_done      = m_have && all_take;
        e_out_valid = m_have ? m_rem : '0;
        if (flush)        e_in_ready = 0;
        else if (!m_have) e_in_ready = !cfg_en;
        else if (m_pendv) e_in_ready = 0;
        else              e_in_ready = e_done && !cfg_en;
    endtask

    task automatic model_commit();
        model_eval();
        if (cnt_clr) m_stall = '0;
        else if (m_have && !e_done && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;

        if (flush) begin
            m_have = 0;
            if (cfg_en) m_act = cfg_mask;
            else if (m_pendv) m_act = m_pend;
            m_pendv = 0;
        end else if (!m_have) begin
            if (cfg_en) m_act = cfg_mask;
            else if (in_valid && m_act != 0) begin
                m_have = 1;
                m_tok  = in_data;
                m_rem  = m_act;
            end
        end else if (e_done) begin
            if (cfg_en) begin
                m_act  = cfg_mask;
                m_have = 0;
            end else if (m_pendv) begin
                m_act  = m_pend;
                m_have = 0;
            end else if (in_valid) begin
                m_tok = in_data;
                m_rem = m_act;
            end else begin
                m_have = 0;
            end
            m_pendv = 0;
        end else begin
            m_rem = m_rem & ~out_ready;
            if (cfg_en) begin
                m_pendv = 1;
                m_pend  = cfg_mask;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 0;
        in_data   = '0;
        out_ready = '0;
        cfg_en    = 0;
        cfg_mask  = '0;
        flush     = 0;
        cnt_clr   = 0;
    endtask

    task automatic configure(input logic [N-1:0] m);
        idle_inputs();
        cfg_en   = 1;
        cfg_mask = m;
        cnt_clr  = 1;
        settle();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL configure obs %h exp %h", obs, exp_vec());
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        checks++;
        if (obs !== {1'b1, {N{1'b0}}, 1'b0, {DW{1'b0}}, {N{1'b0}}, {CW{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset_state obs %h exp in_ready=1 rest 0", obs);
        end
        cfg_en = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready_cfg got %b exp 0", in_ready);
        end
        cfg_en = 0;
        @(negedge clk);
        #2 rst_n = 1;
        advance();
    endtask

    task automatic test_back_to_back();
        configure(6'b000111);
        for (int k = 0; k <= 4; k++) begin
            in_valid  = (k < 4);
            in_data   = DW'(16'h11 + k);
            out_ready = '1;
            settle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc %0d obs %h exp %h", k, obs, exp_vec());
            end
            if (k > 0) begin
                checks++;
                if (out_valid !== 6'b000111 || out_data !== DW'(16'h10 + k) || in_ready !== 1'b1 || stall_cnt !== 4'h0) begin
                    errors++;
                    $display("[TB] FAIL back_to_back_token cyc %0d got v=%b d=%h r=%b s=%0d exp v=000111 d=%h r=1 s=0",
                             k, out_valid, out_data, in_ready, stall_cnt, 16'h10 + k);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_partial_ready();
        configure(6'b000011);
        for (int c = 0; c <= 4; c++) begin
            in_valid     = (c == 0);
            in_data      = 16'h00AB;
            out_ready    = '0;
            out_ready[0] = (c == 1);
            out_ready[1] = (c == 3);
            settle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL partial_ready cyc %0d obs %h exp %h", c, obs, exp_vec());
            end
            if (c == 2) begin
                checks++;
                if (out_valid !== 6'b000010) begin
                    errors++;
                    $display("[TB] FAIL partial_port0_once got %b exp 000010", out_valid);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0 || stall_cnt !== 4'd2) begin
                    errors++;
                    $display("[TB] FAIL partial_drain got busy=%b stall=%0d exp busy=0 stall=2", busy, stall_cnt);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_zero_mask();
        configure('0);
        for (int k = 0; k < 4; k++) begin
            in_valid = (k < 3);
            in_data  = 16'hC0 + 16'(k);
            out_ready = '1;
            settle();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== '0 || busy !== 1'b0 || obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL zero_mask cyc %0d obs %h exp %h", k, obs, exp_vec());
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_reconf();
        configure(6'b000011);
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            case (c)
                0: begin in_valid = 1; in_data = 16'h005A; end
                1: begin out_ready = 6'b000001; cfg_en = 1; cfg_mask = 6'b100000; end
                3: out_ready = 6'b000010;
                4: begin in_valid = 1; in_data = 16'h0077; end
                5: out_ready = '1;
                default: ;
            endcase
            settle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL reconf cyc %0d obs %h exp %h", c, obs, exp_vec());
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 6'b000010 || mask_q !== 6'b000011) begin
                    errors++;
                    $display("[TB] FAIL reconf_hold cyc %0d got r=%b v=%b m=%b exp r=0 v=000010 m=000011",
                             c, in_ready, out_valid, mask_q);
                end
            end
            if (c == 4) begin
                checks++;
                if (mask_q !== 6'b100000 || busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reconf_apply got m=%b busy=%b exp m=100000 busy=0", mask_q, busy);
                end
            end
            if (c == 5) begin
                checks++;
                if (out_valid !== 6'b100000 || out_data !== 16'h0077) begin
                    errors++;
                    $display("[TB] FAIL reconf_new_token got v=%b d=%h exp v=100000 d=0077", out_valid, out_data);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        configure(6'b000111);
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            case (c)
                0: begin in_valid = 1; in_data = 16'h0033; end
                1: out_ready = 6'b000001;
                2: flush = 1;
                default: out_ready = '1;
            endcase
            settle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL flush cyc %0d obs %h exp %h", c, obs, exp_vec());
            end
            if (c == 2) begin
                checks++;
                if (out_valid !== 6'b000110 || in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL flush_cycle got v=%b r=%b exp v=000110 r=0", out_valid, in_ready);
                end
            end
            if (c >= 3) begin
                checks++;
                if (out_valid !== '0 || busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL flush_after cyc %0d got v=%b busy=%b exp v=0 busy=0", c, out_valid, busy);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_stall_saturation();
        configure(6'b000001);
        for (int c = 0; c <= 23; c++) begin
            idle_inputs();
            in_valid  = (c == 0);
            in_data   = 16'h00EE;
            cnt_clr   = (c == 21);
            out_ready = (c == 23) ? 6'b000001 : 6'b000000;
            settle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL stall cyc %0d obs %h exp %h", c, obs, exp_vec());
            end
            if (c == 21) begin
                checks++;
                if (stall_cnt !== 4'hF) begin
                    errors++;
                    $display("[TB] FAIL stall_saturate got %h exp F", stall_cnt);
                end
            end
            if (c == 22) begin
                checks++;
                if (stall_cnt !== 4'h0) begin
                    errors++;
                    $display("[TB] FAIL stall_clear got %h exp 0", stall_cnt);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        configure(6'b001100);
        in_valid = 1;
        in_data  = 16'h0099;
        settle();
        advance();
        idle_inputs();
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== '0 || busy !== 1'b0 || mask_q !== '0 || out_data !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got v=%b busy=%b m=%b d=%h exp all 0", out_valid, busy, mask_q, out_data);
        end
        @(negedge clk);
        #2 rst_n = 1;
        advance();
        for (int c = 0; c < 2; c++) begin
            out_ready = '1;
            settle();
            checks++;
            if (obs !== exp_vec() || out_valid !== '0) begin
                errors++;
                $display("[TB] FAIL async_release cyc %0d obs %h exp %h", c, obs, exp_vec());
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        configure(6'b101101);
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = N'($urandom);
            cfg_en    = ($urandom_range(0, 9) == 0);
            cfg_mask  = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            cnt_clr   = ($urandom_range(0, 29) == 0);
            settle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random cyc %0d obs %h exp %h", c, obs, exp_vec());
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_partial_ready();
        test_zero_mask();
        test_reconf();
        test_flush();
        test_stall_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
